// File: rtl/riscv_uop_pkg.sv
// riscv_uop_pkg
//   Shared micro-op definitions for the execute cluster.
//   uop_t             : decoded ALU micro-op carried from issue to execute.
//   ALU_ISSUE_MAX_REQ : largest requester count alu_issue_arbiter accepts.
package riscv_uop_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [4:0]  rd;
    logic [5:0]  rob_tag;
    logic        use_imm;
  } uop_t;

  localparam int ALU_ISSUE_MAX_REQ = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin priority selector.
//   req     : request vector, one bit per requester.
//   ptr     : index of the highest-priority requester this cycle.
//   gnt     : one-hot grant (zero when no request).
//   gnt_idx : binary index of the granted requester (0 when none).
//   any     : at least one request present.
//   Search runs ptr, ptr+1, ... with explicit wrap so N need not be a
//   power of two.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int             idx;
    logic [IW-1:0]  sel;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares the single ALU execute stage between NUM_REQ issue requesters.
//   One requester wins per cycle (round-robin from rr_ptr) and its uop and
//   operands are registered into a one-entry slot feeding the ALU stage.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     i_req_valid/uop/op1/op2 : per-requester offer
//     o_req_ready         : one-hot (or zero) consume strobe per requester
//     i_stall             : ALU stage not loading; slot frozen
//     i_flush             : empty the slot, no grant this cycle
//     o_valid/o_uop/o_op1/o_op2/o_grant_id : output slot contents
module alu_issue_arbiter
  import riscv_uop_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  uop_t [NUM_REQ-1:0]                 i_req_uop,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       i_req_op1,
  input  logic [NUM_REQ-1:0][XLEN-1:0]       i_req_op2,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic                               i_stall,
  input  logic                               i_flush,
  output logic                               o_valid,
  output uop_t                               o_uop,
  output logic [XLEN-1:0]                    o_op1,
  output logic [XLEN-1:0]                    o_op2,
  output logic [$clog2(NUM_REQ)-1:0]         o_grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ALU_ISSUE_MAX_REQ) begin : g_bad_num_req
    $error("alu_issue_arbiter: NUM_REQ must be in 2..%0d", ALU_ISSUE_MAX_REQ);
  end

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    if (p == IDW'(NUM_REQ - 1)) return '0;
    return p + 1'b1;
  endfunction

  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] cand_oh;
  logic [IDW-1:0]     cand_idx;
  logic               cand_any;
  logic               issue_ok;
  logic               hs_p0;

  logic               vld_p1;
  uop_t               uop_p1;
  logic [XLEN-1:0]    op1_p1;
  logic [XLEN-1:0]    op2_p1;
  logic [IDW-1:0]     id_p1;

  // ---- stage p0: arbitration and handshake ----
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (i_req_valid),
    .ptr     (rr_ptr),
    .gnt     (cand_oh),
    .gnt_idx (cand_idx),
    .any     (cand_any)
  );

  // rst is included so no offer is consumed while the block is held in reset.
  assign issue_ok    = !i_stall && !i_flush && !rst;
  assign o_req_ready = issue_ok ? cand_oh : '0;
  assign hs_p0       = issue_ok && cand_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs_p0) begin
      rr_ptr <= ptr_inc(cand_idx);
    end
  end

  // ---- stage p1: output slot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      uop_p1 <= '0;
      op1_p1 <= '0;
      op2_p1 <= '0;
      id_p1  <= '0;
    end else if (i_flush) begin
      vld_p1 <= 1'b0;
    end else if (!i_stall) begin
      // The slot drains every unstalled cycle; it refills only on a handshake.
      vld_p1 <= hs_p0;
      if (hs_p0) begin
        uop_p1 <= i_req_uop[cand_idx];
        op1_p1 <= i_req_op1[cand_idx];
        op2_p1 <= i_req_op2[cand_idx];
        id_p1  <= cand_idx;
      end
    end
  end

  assign o_valid    = vld_p1;
  assign o_uop      = uop_p1;
  assign o_op1      = op1_p1;
  assign o_op2      = op2_p1;
  assign o_grant_id = id_p1;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
  import riscv_uop_pkg::*;

  localparam int NR = 3;
  localparam int XL = 32;

  typedef struct packed {
    logic [1:0]    id;
    uop_t          uop;
    logic [XL-1:0] op1;
    logic [XL-1:0] op2;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        i_req_valid;
  uop_t [NR-1:0]        i_req_uop;
  logic [NR-1:0][XL-1:0] i_req_op1;
  logic [NR-1:0][XL-1:0] i_req_op2;
  logic [NR-1:0]        o_req_ready;
  logic                 i_stall;
  logic                 i_flush;
  logic                 o_valid;
  uop_t                 o_uop;
  logic [XL-1:0]        o_op1;
  logic [XL-1:0]        o_op2;
  logic [1:0]           o_grant_id;

  alu_issue_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_uop   (i_req_uop),
    .i_req_op1   (i_req_op1),
    .i_req_op2   (i_req_op2),
    .o_req_ready (o_req_ready),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_uop       (o_uop),
    .o_op1       (o_op1),
    .o_op2       (o_op2),
    .o_grant_id  (o_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  int   cyc;
  int   m_ptr;
  logic m_vld;
  exp_t held;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    int j;
    for (int i = 0; i < NR; i++) begin
      j = (p + i) % NR;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [XL-1:0] pay_op1(input int r, input int c);
    return {8'(r + 8'hA0), 24'(c * 7 + 3)};
  endfunction

  function automatic uop_t pay_uop(input int r, input int c);
    uop_t u;
    u.op      = alu_op_e'(4'(c % 10));
    u.rd      = 5'(r * 9 + 1);
    u.rob_tag = 6'(c);
    u.use_imm = c[0];
    return u;
  endfunction

  // Drives one cycle starting from a negedge; returns at the next negedge.
  task automatic cycle(input logic [NR-1:0] v, input logic st, input logic fl);
    int            k;
    logic          hs;
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    i_req_valid = v;
    i_stall     = st;
    i_flush     = fl;
    for (int r = 0; r < NR; r++) begin
      logic [1:0] ri;
      ri = 2'(r);
      i_req_uop[ri] = pay_uop(r, cyc);
      i_req_op1[ri] = pay_op1(r, cyc);
      i_req_op2[ri] = ~pay_op1(r, cyc) ^ 32'h5A5A_0000;
    end
    #1;
    hs      = 1'b0;
    exp_rdy = '0;
    k       = -1;
    if (!st && !fl) k = pick(v, m_ptr);
    if (k >= 0) begin
      hs = 1'b1;
      exp_rdy[k[1:0]] = 1'b1;
    end
    check_val("ready", 64'(o_req_ready), 64'(exp_rdy));
    if (hs) begin
      e.id  = k[1:0];
      e.uop = pay_uop(k, cyc);
      e.op1 = pay_op1(k, cyc);
      e.op2 = ~pay_op1(k, cyc) ^ 32'h5A5A_0000;
      sb_q.push_back(e);
      m_ptr = (k + 1) % NR;
    end
    if (fl) m_vld = 1'b0;
    else if (!st) m_vld = hs;
    @(posedge clk);
    #1;
    check_val("valid", 64'(o_valid), 64'(m_vld));
    if (hs) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 64'd1, 64'd0);
      end else begin
        held = sb_q.pop_front();
      end
    end
    if (m_vld) begin
      check_val("grant_id", 64'(o_grant_id), 64'(held.id));
      check_val("uop",      64'(o_uop),      64'(held.uop));
      check_val("op1",      64'(o_op1),      64'(held.op1));
      check_val("op2",      64'(o_op2),      64'(held.op2));
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_req_valid = '1;
    i_stall     = 1'b0;
    i_flush     = 1'b0;
    #1;
    check_val("rst_ready", 64'(o_req_ready), 64'd0);
    check_val("rst_valid", 64'(o_valid), 64'd0);
    check_val("rst_uop",   64'(o_uop), 64'd0);
    check_val("rst_op1",   64'(o_op1), 64'd0);
    check_val("rst_op2",   64'(o_op2), 64'd0);
    check_val("rst_id",    64'(o_grant_id), 64'd0);
    @(posedge clk);
    #1;
    check_val("rst_valid_edge", 64'(o_valid), 64'd0);
    check_val("rst_ready_edge", 64'(o_req_ready), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    m_vld = 1'b0;
    sb_q.delete();
  endtask

  int fair_exp[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_ptr = 0;
    m_vld = 1'b0;
    held  = '0;
    rst         = 1'b1;
    i_req_valid = '0;
    i_req_uop   = '0;
    i_req_op1   = '0;
    i_req_op2   = '0;
    i_stall     = 1'b0;
    i_flush     = 1'b0;
    @(negedge clk);
    do_reset();

    // reset release then fairness: all valid for six cycles
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, 1'b0, 1'b0);
      check_val("fair_id", 64'(o_grant_id), 64'(fair_exp[i]));
      check_val("fair_valid", 64'(o_valid), 64'd1);
    end

    // stall with uop A in the slot and req1 waiting
    cycle(3'b001, 1'b0, 1'b0);
    check_val("stallA_id", 64'(o_grant_id), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b010, 1'b1, 1'b0);
      check_val("stall_hold_id", 64'(o_grant_id), 64'd0);
    end
    cycle(3'b010, 1'b0, 1'b0);
    check_val("stall_rel_id", 64'(o_grant_id), 64'd1);

    // flush together with stall while full; pointer must still be 2
    cycle(3'b111, 1'b1, 1'b1);
    check_val("flush_valid", 64'(o_valid), 64'd0);
    cycle(3'b111, 1'b0, 1'b0);
    check_val("flush_ptr_id", 64'(o_grant_id), 64'd2);

    // wrap-around
    cycle(3'b001, 1'b0, 1'b0);
    check_val("wrap0_id", 64'(o_grant_id), 64'd0);
    cycle(3'b011, 1'b0, 1'b0);
    check_val("wrap1_id", 64'(o_grant_id), 64'd1);
    cycle(3'b001, 1'b0, 1'b0);
    check_val("wrap_last_id", 64'(o_grant_id), 64'd0);
    cycle(3'b011, 1'b0, 1'b0);
    check_val("wrap_next_id", 64'(o_grant_id), 64'd1);

    // flush alone, then bubble; pointer stays at 2
    cycle(3'b111, 1'b0, 1'b1);
    check_val("flush_only_valid", 64'(o_valid), 64'd0);
    cycle(3'b000, 1'b0, 1'b0);
    check_val("bubble_valid0", 64'(o_valid), 64'd0);
    cycle(3'b000, 1'b0, 1'b0);
    check_val("bubble_valid1", 64'(o_valid), 64'd0);
    cycle(3'b111, 1'b0, 1'b0);
    check_val("bubble_ptr_id", 64'(o_grant_id), 64'd2);

    // single requester granted every cycle
    for (int i = 0; i < 3; i++) begin
      cycle(3'b010, 1'b0, 1'b0);
      check_val("single_id", 64'(o_grant_id), 64'd1);
    end

    // random traffic against the scoreboard
    for (int i = 0; i < 80; i++) begin
      cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0));
    end

    // reset mid-operation discards the slot
    cycle(3'b111, 1'b0, 1'b0);
    do_reset();
    cycle(3'b111, 1'b0, 1'b0);
    check_val("post_rst_id", 64'(o_grant_id), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
